// File: rtl/fpu_addsub_ctrl.sv
// Sequencing controller for the single-precision add/sub unit.
// Takes one operation at a time, resolves IEEE special cases locally
// and only launches the multi-cycle normal datapath when no special case applies.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | ready for a request, operands captured on acceptance
// S_CLASSIFY | operands checked for NaN/inf/zero/equal-magnitude cases
// S_DP_START | one-cycle launch pulse to the normal datapath
// S_DP_WAIT  | waiting for dp_done, bounded by TIMEOUT_CYC cycles
// S_RESULT   | flag/copied operand/signs presented until downstream accepts
module fpu_addsub_ctrl #(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             dp_start,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_sub,
  input  logic             dp_done,
  output logic [2:0]       exception_flag,
  output logic [WIDTH-2:0] copied_operand,
  output logic             sign_a,
  output logic             sign_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             timeout_err
);

  localparam int EXP_W = 8;
  localparam int MAN_W = WIDTH - 1 - EXP_W;

  localparam logic [2:0] FLAG_NONE      = 3'b000;
  localparam logic [2:0] FLAG_NAN       = 3'b001;
  localparam logic [2:0] FLAG_COPY_A    = 3'b010;
  localparam logic [2:0] FLAG_COPY_B    = 3'b011;
  localparam logic [2:0] FLAG_FIN_M_INF = 3'b100;
  localparam logic [2:0] FLAG_ZERO_ZERO = 3'b101;
  localparam logic [2:0] FLAG_ZERO_M_NZ = 3'b110;
  localparam logic [2:0] FLAG_SUB_EQUAL = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_DP_START,
    S_DP_WAIT,
    S_RESULT
  } state_t;

  state_t state;

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;

  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] man_a;
  logic [MAN_W-1:0] man_b;
  logic [WIDTH-2:0] mag_a;
  logic [WIDTH-2:0] mag_b;

  logic a_nan, b_nan;
  logic a_inf, b_inf;
  logic a_zero, b_zero;
  logic eff_sub;

  logic [2:0]       class_flag;
  logic [WIDTH-2:0] class_copied;

  assign mag_a = dp_a[WIDTH-2:0];
  assign mag_b = dp_b[WIDTH-2:0];
  assign exp_a = dp_a[WIDTH-2 -: EXP_W];
  assign exp_b = dp_b[WIDTH-2 -: EXP_W];
  assign man_a = dp_a[MAN_W-1:0];
  assign man_b = dp_b[MAN_W-1:0];

  assign wait_cnt_next = wait_cnt + 1'b1;

  // Operand field decode on the captured operands
  always_comb begin
    a_nan   = (exp_a == '1) && (man_a != '0);
    b_nan   = (exp_b == '1) && (man_b != '0);
    a_inf   = (exp_a == '1) && (man_a == '0);
    b_inf   = (exp_b == '1) && (man_b == '0);
    a_zero  = (exp_a == '0) && (man_a == '0);
    b_zero  = (exp_b == '0) && (man_b == '0);
    eff_sub = dp_sub ^ sign_a ^ sign_b;
  end

  // Special-case classification, first matching rule wins
  always_comb begin
    class_flag   = FLAG_NONE;
    class_copied = '0;
    if (a_nan || b_nan) begin
      class_flag = FLAG_NAN;
    end else if (a_inf && b_inf && eff_sub) begin
      class_flag = FLAG_NAN;
    end else if (a_inf) begin
      class_flag   = FLAG_COPY_A;
      class_copied = mag_a;
    end else if (b_inf) begin
      if (dp_sub) begin
        class_flag = FLAG_FIN_M_INF;
      end else begin
        class_flag   = FLAG_COPY_B;
        class_copied = mag_b;
      end
    end else if (a_zero && b_zero) begin
      class_flag = FLAG_ZERO_ZERO;
    end else if (a_zero) begin
      class_flag   = dp_sub ? FLAG_ZERO_M_NZ : FLAG_COPY_B;
      class_copied = mag_b;
    end else if (b_zero) begin
      class_flag   = FLAG_COPY_A;
      class_copied = mag_a;
    end else if ((mag_a == mag_b) && eff_sub) begin
      class_flag = FLAG_SUB_EQUAL;
    end
  end

  // Sequencing FSM; every output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      in_ready       <= 1'b1;
      dp_start       <= 1'b0;
      dp_a           <= '0;
      dp_b           <= '0;
      dp_sub         <= 1'b0;
      exception_flag <= FLAG_NONE;
      copied_operand <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      out_valid      <= 1'b0;
      timeout_err    <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      dp_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dp_a     <= op_a;
            dp_b     <= op_b;
            dp_sub   <= op_sub;
            sign_a   <= op_a[WIDTH-1];
            sign_b   <= op_b[WIDTH-1];
            in_ready <= 1'b0;
            state    <= S_CLASSIFY;
          end
        end

        S_CLASSIFY: begin
          exception_flag <= class_flag;
          copied_operand <= class_copied;
          if (class_flag != FLAG_NONE) begin
            out_valid <= 1'b1;
            state     <= S_RESULT;
          end else begin
            dp_start <= 1'b1;
            state    <= S_DP_START;
          end
        end

        S_DP_START: begin
          wait_cnt <= '0;
          state    <= S_DP_WAIT;
        end

        S_DP_WAIT: begin
          wait_cnt <= wait_cnt_next;
          // dp_done on the final allowed cycle still wins over the timeout
          if (dp_done) begin
            exception_flag <= FLAG_NONE;
            out_valid      <= 1'b1;
            state          <= S_RESULT;
          end else if (wait_cnt_next == CNT_LIMIT) begin
            exception_flag <= FLAG_NAN;
            copied_operand <= '0;
            timeout_err    <= 1'b1;
            out_valid      <= 1'b1;
            state          <= S_RESULT;
          end
        end

        S_RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
// Directed bench for fpu_addsub_ctrl: special-case classification,
// normal-path handshake with backpressure, timeout and reset abandonment.
module tb_fpu_addsub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        dp_start;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic        dp_sub;
  logic        dp_done;
  logic [2:0]  exception_flag;
  logic [30:0] copied_operand;
  logic        sign_a;
  logic        sign_b;
  logic        out_valid;
  logic        out_ready;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;

  fpu_addsub_ctrl #(
    .WIDTH      (32),
    .TIMEOUT_CYC(16),
    .CNT_W      (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_sub        (op_sub),
    .dp_start      (dp_start),
    .dp_a          (dp_a),
    .dp_b          (dp_b),
    .dp_sub        (dp_sub),
    .dp_done       (dp_done),
    .exception_flag(exception_flag),
    .copied_operand(copied_operand),
    .sign_a        (sign_a),
    .sign_b        (sign_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count launch pulses (one per clock cycle dp_start is high)
  always @(negedge clk) if (dp_start) n_start++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    check_eq("send_ready", {31'd0, in_ready}, 32'd1);
    op_a     = a;
    op_b     = b;
    op_sub   = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // scramble inputs so any use of unregistered operands shows up
    op_a     = 32'hDEADBEEF;
    op_b     = 32'h12345678;
    op_sub   = ~s;
    check_eq("accept_busy", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic special(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] flag, input logic [31:0] copied);
    int s0;
    s0 = n_start;
    send(a, b, s);
    step();
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_flag"}, {29'd0, exception_flag}, {29'd0, flag});
    check_eq({tag, "_copied"}, {1'b0, copied_operand}, copied);
    check_eq({tag, "_sign_a"}, {31'd0, sign_a}, {31'd0, a[31]});
    check_eq({tag, "_sign_b"}, {31'd0, sign_b}, {31'd0, b[31]});
    check_eq({tag, "_nostart"}, n_start - s0, 32'd0);
    step();
    check_eq({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_done_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic normal(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int delay, input logic hold);
    int s0;
    s0 = n_start;
    out_ready = ~hold;
    send(a, b, s);
    step();
    check_eq({tag, "_start"}, {31'd0, dp_start}, 32'd1);
    check_eq({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_dp_a"}, dp_a, a);
    check_eq({tag, "_dp_b"}, dp_b, b);
    check_eq({tag, "_dp_sub"}, {31'd0, dp_sub}, {31'd0, s});
    step();
    check_eq({tag, "_start_pulse"}, {31'd0, dp_start}, 32'd0);
    repeat (delay - 1) step();
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_flag"}, {29'd0, exception_flag}, 32'd0);
    check_eq({tag, "_copied"}, {1'b0, copied_operand}, 32'd0);
    check_eq({tag, "_one_start"}, n_start - s0, 32'd1);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        step();
        check_eq({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_hold_flag"}, {29'd0, exception_flag}, 32'd0);
        check_eq({tag, "_hold_signs"}, {30'd0, sign_a, sign_b}, {30'd0, a[31], b[31]});
        check_eq({tag, "_hold_busy"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    step();
    check_eq({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_done_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int w;
    int v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    dp_done   = 1'b0;
    out_ready = 1'b1;
    #23;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_dp_start", {31'd0, dp_start}, 32'd0);
    check_eq("rst_flag", {29'd0, exception_flag}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check_eq("rst_dp_a", dp_a, 32'd0);
    rst_n = 1'b1;
    step();

    // special cases
    special("fin_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 3'b100, 32'h00000000);
    special("sub_equal",     32'h40400000, 32'h40400000, 1'b1, 3'b111, 32'h00000000);
    special("nan_a",         32'h7FC00000, 32'h3F800000, 1'b0, 3'b001, 32'h00000000);
    special("inf_opp_add",   32'hFF800000, 32'h7F800000, 1'b0, 3'b001, 32'h00000000);
    special("zero_minus_nz", 32'h00000000, 32'hBF800000, 1'b1, 3'b110, 32'h3F800000);
    special("zero_zero",     32'h80000000, 32'h80000000, 1'b0, 3'b101, 32'h00000000);
    special("inf_a",         32'h7F800000, 32'h3F800000, 1'b1, 3'b010, 32'h7F800000);
    special("inf_inf_same",  32'h7F800000, 32'h7F800000, 1'b0, 3'b010, 32'h7F800000);
    special("inf_b_add",     32'h3F800000, 32'h7F800000, 1'b0, 3'b011, 32'h7F800000);
    special("zero_a_add",    32'h00000000, 32'h40000000, 1'b0, 3'b011, 32'h40000000);
    special("zero_b",        32'h40400000, 32'h00000000, 1'b1, 3'b010, 32'h40400000);
    special("eq_opp_add",    32'h40400000, 32'hC0400000, 1'b0, 3'b111, 32'h00000000);

    // normal path
    normal("norm_hold",  32'h3F800000, 32'h40000000, 1'b0, 5, 1'b1);
    normal("norm_eqadd", 32'h40400000, 32'h40400000, 1'b0, 2, 1'b0);
    normal("norm_edge",  32'hC1200000, 32'h3F800000, 1'b1, 16, 1'b0);
    check_eq("edge_no_timeout", {31'd0, timeout_err}, 32'd0);

    // timeout: dp_done never comes
    v = n_start;
    send(32'h3F800000, 32'h40000000, 1'b0);
    step();
    check_eq("to_start", {31'd0, dp_start}, 32'd1);
    w = 0;
    while (!out_valid && w < 40) begin
      step();
      w++;
    end
    check_eq("to_latency", w, 32'd17);
    check_eq("to_flag", {29'd0, exception_flag}, 32'd1);
    check_eq("to_copied", {1'b0, copied_operand}, 32'd0);
    check_eq("to_err", {31'd0, timeout_err}, 32'd1);
    check_eq("to_one_start", n_start - v, 32'd1);
    step();
    check_eq("to_back_idle", {31'd0, in_ready}, 32'd1);

    // late dp_done in IDLE
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    check_eq("late_done_valid", {31'd0, out_valid}, 32'd0);
    check_eq("late_done_ready", {31'd0, in_ready}, 32'd1);
    check_eq("late_done_start", {31'd0, dp_start}, 32'd0);
    step();
    check_eq("late_done_valid2", {31'd0, out_valid}, 32'd0);

    special("after_to", 32'h3F800000, 32'h7F800000, 1'b1, 3'b100, 32'h00000000);
    check_eq("to_sticky", {31'd0, timeout_err}, 32'd1);

    // reset in the middle of DP_WAIT
    send(32'h3F800000, 32'h40000000, 1'b0);
    step();
    check_eq("rm_start", {31'd0, dp_start}, 32'd1);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rm_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rm_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rm_dp_start", {31'd0, dp_start}, 32'd0);
    check_eq("rm_timeout_clr", {31'd0, timeout_err}, 32'd0);
    #3;
    rst_n = 1'b1;
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    v = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || dp_start) v++;
      step();
    end
    check_eq("rm_no_stale", v, 32'd0);
    check_eq("rm_idle_ready", {31'd0, in_ready}, 32'd1);

    special("post_rst", 32'h40400000, 32'h40400000, 1'b1, 3'b111, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_ctrl.md
Name: fpu_addsub_ctrl

Overview:
- Sequencing controller for the single-precision add/sub unit.
- Accepts one operation at a time over a valid/ready handshake and classifies the operands for IEEE special cases.
- For special cases it produces the 3-bit exception flag and the copied operand for the result-select stage directly.
- Otherwise it launches the multi-cycle normal datapath, waits for completion (with timeout), and presents flag and signs to the select stage until downstream accepts.

Parameters:
- WIDTH, 32, operand width; only 32 is supported (8-bit exponent, 23-bit mantissa).
- TIMEOUT_CYC, 16, max cycles to wait for dp_done before aborting with NaN.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_sub  in  1  1 = A-B, 0 = A+B.
- dp_start  out  1  one-cycle pulse launching the normal datapath.
- dp_a  out  WIDTH  registered A to datapath.
- dp_b  out  WIDTH  registered B to datapath.
- dp_sub  out  1  registered op_sub.
- dp_done  in  1  datapath result ready (single-cycle pulse).
- exception_flag  out  3  flag to the select stage.
- copied_operand  out  WIDTH-1  magnitude to the select stage.
- sign_a  out  1  registered sign of A.
- sign_b  out  1  registered sign of B.
- out_valid  out  1  flag/result fields valid.
- out_ready  in  1  downstream accepts.
- timeout_err  out  1  sticky; set on datapath timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except in_ready=1; counters cleared. Reset mid-operation abandons the operation; no out_valid is produced for it.
- Flag encoding:
  - 000 none
  - 001 NaN
  - 010 copy A
  - 011 copy B
  - 100 finite minus inf
  - 101 zero op zero
  - 110 zero minus nonzero
  - 111 subtract equal values
- Field definitions: E=exp field, M=mantissa. NaN: E=FF, M!=0. Inf: E=FF, M=0. Zero: E=0, M=0. Effective subtraction eff_sub = op_sub ^ sign_a ^ sign_b.
- Classification priority (first match wins):
  1. Either operand NaN -> 001.
  2. Both inf and eff_sub -> 001.
  3. A inf -> 010, copied=A[30:0].
  4. B inf: op_sub=0 -> 011, copied=B[30:0]; op_sub=1 -> 100.
  5. Both zero -> 101, copied=0.
  6. A zero: op_sub=0 -> 011, copied=B[30:0]; op_sub=1 -> 110, copied=B[30:0].
  7. B zero -> 010, copied=A[30:0].
  8. A[30:0]==B[30:0] and eff_sub -> 111, copied=0.
  9. Otherwise -> 000, copied=0 (normal path).
- FSM states: IDLE, CLASSIFY, DP_START, DP_WAIT, RESULT.
  - IDLE: in_ready=1. When in_valid, register operands, op_sub and signs; go to CLASSIFY.
  - CLASSIFY: in_ready=0. Compute and register flag and copied operand. Flag!=000 -> RESULT; flag=000 -> DP_START.
  - DP_START: dp_start=1 for exactly one cycle; timeout counter cleared; go to DP_WAIT.
  - DP_WAIT: counter increments each cycle.
    - dp_done -> RESULT with flag 000.
    - Counter reaches TIMEOUT_CYC without dp_done -> flag=001, timeout_err=1, go to RESULT.
  - RESULT: out_valid=1. exception_flag, copied_operand, sign_a and sign_b are held stable until out_ready. On out_valid & out_ready: clear out_valid, go to IDLE, in_ready=1 the next cycle. No back-to-back acceptance in the same cycle.
- Latency (out_ready held high):
  - Special case: accept at cycle 0 -> out_valid at cycle 2.
  - Normal: dp_start at cycle 2; dp_done at cycle k -> out_valid at cycle k+1.
- Ignored inputs: dp_done outside DP_WAIT is ignored. dp_done in the same cycle the counter hits TIMEOUT_CYC counts as done (no error).
- in_valid while in_ready=0 is ignored; the requester must hold it.
- dp_a, dp_b and dp_sub are stable from CLASSIFY until return to IDLE.

Test Plan:
- Reset asserted mid-DP_WAIT -> out_valid=0, in_ready=1, dp_start=0 immediately; no stale out_valid after release.
- A=3F800000, B=7F800000, op_sub=1 -> exception_flag=100, sign_b=0, out_valid at cycle 2, no dp_start.
- A=40400000, B=40400000, op_sub=1 -> flag=111, copied=0. A=7FC00000, B=3F800000 -> flag=001. A=FF800000 + B=7F800000 -> flag=001.
- A=00000000, B=BF800000, op_sub=1 -> flag=110, copied=3F800000, sign_b=1. A=80000000, B=80000000, add -> flag=101, sign_a=sign_b=1.
- A=3F800000 + B=40000000, dp_done 5 cycles after dp_start -> one dp_start pulse, flag=000, out_valid one cycle after dp_done. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- Normal op with dp_done never asserted -> after 16 wait cycles flag=001, timeout_err=1 (sticky across later ops); a late dp_done in IDLE has no effect.
